// File: rtl/mprj_wb_guard_pkg.sv
// Shared types and constants for the management-to-user-project Wishbone guard.
package mprj_wb_guard_pkg;

    // Guard FSM state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Read data handed back to the master when a transfer is blocked or times out.
    localparam logic [31:0] FAIL_DATA_DEFAULT = 32'hDEADBEEF;

    // Width of the wait counter that bounds a forwarded transfer.
    localparam int CNT_W = 16;

    // Fault counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wb_wait_counter.sv
// Clear/enable up-counter with an equality compare against a terminal value.
module wb_wait_counter #(
    parameter int W = 16
) (
    input  logic         core_clk,
    input  logic         core_rstn,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         at_term
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority over counting.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!core_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_term = (cnt_q == term);

endmodule

// File: rtl/mprj_wb_guard.sv
// Wishbone guard between the management core and the user project: forwards
// requests, bounds the wait for an ack, and records timeouts as faults.
module mprj_wb_guard
    import mprj_wb_guard_pkg::*;
#(
    parameter logic [15:0] TIMEOUT   = 16'd255,
    parameter logic [31:0] FAIL_DATA = FAIL_DATA_DEFAULT
) (
    input  logic        core_clk,
    input  logic        core_rstn,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    input  logic        m_we_i,
    input  logic [3:0]  m_sel_i,
    input  logic [31:0] m_adr_i,
    input  logic [31:0] m_dat_i,
    output logic        m_ack_o,
    output logic [31:0] m_dat_o,
    output logic        mprj_cyc_o,
    output logic        mprj_stb_o,
    output logic        mprj_we_o,
    output logic [3:0]  mprj_sel_o,
    output logic [31:0] mprj_adr_o,
    output logic [31:0] mprj_dat_o,
    input  logic        mprj_ack_i,
    input  logic [31:0] mprj_dat_i,
    input  logic        wb_iena,
    input  logic        fault_clr,
    output logic        timeout_irq,
    output logic [31:0] fault_adr,
    output logic [7:0]  fault_cnt
);

    // Counter value on the last allowed BUSY cycle.
    localparam logic [CNT_W-1:0] TERM = TIMEOUT - 16'd1;

    state_e state_q, state_d;

    logic        mprj_cyc_q, mprj_cyc_d;
    logic        mprj_stb_q, mprj_stb_d;
    logic        mprj_we_q,  mprj_we_d;
    logic [3:0]  mprj_sel_q, mprj_sel_d;
    logic [31:0] mprj_adr_q, mprj_adr_d;
    logic [31:0] mprj_dat_q, mprj_dat_d;
    logic [31:0] m_dat_q,    m_dat_d;
    logic        irq_q,      irq_d;
    logic [31:0] fault_adr_q, fault_adr_d;
    logic [7:0]  fault_cnt_q, fault_cnt_d;
    logic [7:0]  cnt_base;

    logic fwd_evt, blk_evt, ack_evt, abort_evt, to_evt;
    logic at_term;

    wb_wait_counter #(.W(CNT_W)) u_wait_cnt (
        .core_clk  (core_clk),
        .core_rstn (core_rstn),
        .clr       (fwd_evt),
        .en        (state_q == BUSY),
        .term      (TERM),
        .at_term   (at_term)
    );

    // State register.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in BUSY a master abort beats an ack, and an ack beats a timeout.
    always_comb begin
        state_d   = state_q;
        fwd_evt   = 1'b0;
        blk_evt   = 1'b0;
        ack_evt   = 1'b0;
        abort_evt = 1'b0;
        to_evt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    fwd_evt = wb_iena;
                    blk_evt = !wb_iena;
                    state_d = wb_iena ? BUSY : RESP;
                end
            end
            BUSY: begin
                if (!m_cyc_i) begin
                    abort_evt = 1'b1;
                    state_d   = IDLE;
                end else if (mprj_ack_i && wb_iena) begin
                    ack_evt = 1'b1;
                    state_d = RESP;
                end else if (at_term) begin
                    to_evt  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output: the master ack is exactly the single RESP cycle.
    always_comb begin
        m_ack_o = (state_q == RESP);
    end

    // Datapath next values: request latch, response data and fault bookkeeping.
    always_comb begin
        mprj_cyc_d  = mprj_cyc_q;
        mprj_stb_d  = mprj_stb_q;
        mprj_we_d   = mprj_we_q;
        mprj_sel_d  = mprj_sel_q;
        mprj_adr_d  = mprj_adr_q;
        mprj_dat_d  = mprj_dat_q;
        m_dat_d     = m_dat_q;
        fault_adr_d = fault_adr_q;

        if (fwd_evt) begin
            mprj_cyc_d = 1'b1;
            mprj_stb_d = 1'b1;
            mprj_we_d  = m_we_i;
            mprj_sel_d = m_sel_i;
            mprj_adr_d = m_adr_i;
            mprj_dat_d = m_dat_i;
        end
        if (blk_evt) begin
            m_dat_d = FAIL_DATA;
        end
        if (ack_evt) begin
            mprj_cyc_d = 1'b0;
            mprj_stb_d = 1'b0;
            m_dat_d    = mprj_we_q ? 32'h0 : mprj_dat_i;
        end
        if (abort_evt) begin
            mprj_cyc_d = 1'b0;
            mprj_stb_d = 1'b0;
        end
        if (to_evt) begin
            mprj_cyc_d  = 1'b0;
            mprj_stb_d  = 1'b0;
            m_dat_d     = FAIL_DATA;
            fault_adr_d = mprj_adr_q;
        end

        // Clear is applied first so a coincident timeout still lands as a fresh fault.
        cnt_base    = fault_clr ? 8'h00 : fault_cnt_q;
        irq_d       = fault_clr ? 1'b0  : irq_q;
        fault_cnt_d = cnt_base;
        if (to_evt) begin
            irq_d       = 1'b1;
            fault_cnt_d = sat_inc8(cnt_base);
        end
    end

    // Datapath registers.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        // NOTE: every datapath register is reset so all outputs read zero while reset is held.
        if (!core_rstn) begin
            mprj_cyc_q  <= 1'b0;
            mprj_stb_q  <= 1'b0;
            mprj_we_q   <= 1'b0;
            mprj_sel_q  <= 4'h0;
            mprj_adr_q  <= 32'h0;
            mprj_dat_q  <= 32'h0;
            m_dat_q     <= 32'h0;
            irq_q       <= 1'b0;
            fault_adr_q <= 32'h0;
            fault_cnt_q <= 8'h00;
        end else begin
            mprj_cyc_q  <= mprj_cyc_d;
            mprj_stb_q  <= mprj_stb_d;
            mprj_we_q   <= mprj_we_d;
            mprj_sel_q  <= mprj_sel_d;
            mprj_adr_q  <= mprj_adr_d;
            mprj_dat_q  <= mprj_dat_d;
            m_dat_q     <= m_dat_d;
            irq_q       <= irq_d;
            fault_adr_q <= fault_adr_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign mprj_cyc_o  = mprj_cyc_q;
    assign mprj_stb_o  = mprj_stb_q;
    assign mprj_we_o   = mprj_we_q;
    assign mprj_sel_o  = mprj_sel_q;
    assign mprj_adr_o  = mprj_adr_q;
    assign mprj_dat_o  = mprj_dat_q;
    assign m_dat_o     = m_dat_q;
    assign timeout_irq = irq_q;
    assign fault_adr   = fault_adr_q;
    assign fault_cnt   = fault_cnt_q;

endmodule

// File: tb/tb_mprj_wb_guard.sv
// Self-checking bench for mprj_wb_guard with a transaction-level reference model.
module tb_mprj_wb_guard;

    localparam int          T    = 8;
    localparam logic [31:0] FAIL_WORD = 32'hDEADBEEF;

    logic        core_clk;
    logic        core_rstn;
    logic        m_cyc_i, m_stb_i, m_we_i;
    logic [3:0]  m_sel_i;
    logic [31:0] m_adr_i, m_dat_i;
    logic        m_ack_o;
    logic [31:0] m_dat_o;
    logic        mprj_cyc_o, mprj_stb_o, mprj_we_o;
    logic [3:0]  mprj_sel_o;
    logic [31:0] mprj_adr_o, mprj_dat_o;
    logic        mprj_ack_i;
    logic [31:0] mprj_dat_i;
    logic        wb_iena;
    logic        fault_clr;
    logic        timeout_irq;
    logic [31:0] fault_adr;
    logic [7:0]  fault_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference fault state.
    int          exp_cnt = 0;
    logic        exp_irq = 1'b0;
    logic [31:0] exp_adr = 32'h0;

    mprj_wb_guard #(.TIMEOUT(16'd8)) dut (
        .core_clk    (core_clk),
        .core_rstn   (core_rstn),
        .m_cyc_i     (m_cyc_i),
        .m_stb_i     (m_stb_i),
        .m_we_i      (m_we_i),
        .m_sel_i     (m_sel_i),
        .m_adr_i     (m_adr_i),
        .m_dat_i     (m_dat_i),
        .m_ack_o     (m_ack_o),
        .m_dat_o     (m_dat_o),
        .mprj_cyc_o  (mprj_cyc_o),
        .mprj_stb_o  (mprj_stb_o),
        .mprj_we_o   (mprj_we_o),
        .mprj_sel_o  (mprj_sel_o),
        .mprj_adr_o  (mprj_adr_o),
        .mprj_dat_o  (mprj_dat_o),
        .mprj_ack_i  (mprj_ack_i),
        .mprj_dat_i  (mprj_dat_i),
        .wb_iena     (wb_iena),
        .fault_clr   (fault_clr),
        .timeout_irq (timeout_irq),
        .fault_adr   (fault_adr),
        .fault_cnt   (fault_cnt)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_faults(input string tag);
        check({tag, ".fault_cnt"}, {24'h0, fault_cnt}, exp_cnt[31:0]);
        check({tag, ".timeout_irq"}, {31'h0, timeout_irq}, {31'h0, exp_irq});
        check({tag, ".fault_adr"}, fault_adr, exp_adr);
    endtask

    // One master transfer. ack_at is the BUSY cycle index (from 0) in which the
    // user acks (-1: never); clr_at is the BUSY cycle index carrying fault_clr.
    task automatic xfer(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                        input logic we, input logic [3:0] sel, input logic iena_req,
                        input logic iena_busy, input int ack_at, input logic [31:0] udat,
                        input int clr_at);
        logic [31:0] exp_data;
        int          exp_stb;
        int          exp_n;
        bit          timeout;
        int          n;
        int          stb_cyc;
        bit          got;

        // Reference model: outcome of the transfer from the guard's rules.
        timeout = 1'b0;
        if (!iena_req) begin
            exp_stb  = 0;
            exp_data = FAIL_WORD;
            exp_n    = 1;
        end else if (iena_busy && ack_at >= 0 && ack_at < T) begin
            exp_stb  = ack_at + 1;
            exp_data = we ? 32'h0 : udat;
            exp_n    = ack_at + 2;
        end else begin
            exp_stb  = T;
            exp_data = FAIL_WORD;
            exp_n    = T + 1;
            timeout  = 1'b1;
        end
        if (clr_at >= 0 && clr_at < exp_stb) begin
            exp_cnt = 0;
            exp_irq = 1'b0;
        end
        if (timeout) begin
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            exp_irq = 1'b1;
            exp_adr = adr;
        end

        @(negedge core_clk);
        m_cyc_i    = 1'b1;
        m_stb_i    = 1'b1;
        m_we_i     = we;
        m_sel_i    = sel;
        m_adr_i    = adr;
        m_dat_i    = dat;
        wb_iena    = iena_req;
        mprj_ack_i = 1'b0;
        fault_clr  = 1'b0;
        n = 0;
        stb_cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge core_clk);
            n++;
            mprj_ack_i = 1'b0;
            fault_clr  = 1'b0;
            if (m_ack_o) begin
                got = 1'b1;
                // Ack and data during RESP must be ignored.
                mprj_ack_i = 1'b1;
                mprj_dat_i = $urandom;
                m_cyc_i    = 1'b0;
                m_stb_i    = 1'b0;
            end else if (mprj_stb_o) begin
                check({tag, ".cyc"}, {31'h0, mprj_cyc_o}, 32'h1);
                check({tag, ".adr"}, mprj_adr_o, adr);
                check({tag, ".wdat"}, mprj_dat_o, dat);
                check({tag, ".we"}, {31'h0, mprj_we_o}, {31'h0, we});
                check({tag, ".sel"}, {28'h0, mprj_sel_o}, {28'h0, sel});
                wb_iena    = iena_busy;
                mprj_dat_i = (stb_cyc == ack_at) ? udat : $urandom;
                mprj_ack_i = (stb_cyc == ack_at);
                fault_clr  = (stb_cyc == clr_at);
                stb_cyc++;
            end
        end
        check({tag, ".ack_seen"}, {31'h0, got}, 32'h1);
        check({tag, ".latency"}, n, exp_n);
        check({tag, ".stb_cycles"}, stb_cyc, exp_stb);
        check({tag, ".rdata"}, m_dat_o, exp_data);
        check_faults(tag);

        // One cycle later: ack gone, data held, downstream idle.
        @(negedge core_clk);
        mprj_ack_i = 1'b0;
        wb_iena    = 1'b1;
        check({tag, ".ack_1cyc"}, {31'h0, m_ack_o}, 32'h0);
        check({tag, ".rdata_hold"}, m_dat_o, exp_data);
        check({tag, ".stb_idle"}, {31'h0, mprj_stb_o}, 32'h0);
    endtask

    initial begin
        core_rstn  = 1'b0;
        m_cyc_i    = 1'b0;
        m_stb_i    = 1'b0;
        m_we_i     = 1'b0;
        m_sel_i    = 4'h0;
        m_adr_i    = 32'h0;
        m_dat_i    = 32'h0;
        mprj_ack_i = 1'b0;
        mprj_dat_i = 32'h0;
        wb_iena    = 1'b1;
        fault_clr  = 1'b0;

        // Reset state.
        repeat (3) @(negedge core_clk);
        check("rst.m_ack", {31'h0, m_ack_o}, 32'h0);
        check("rst.m_dat", m_dat_o, 32'h0);
        check("rst.stb", {31'h0, mprj_stb_o}, 32'h0);
        check("rst.adr", mprj_adr_o, 32'h0);
        check_faults("rst");
        core_rstn = 1'b1;
        @(negedge core_clk);

        // Plain read acked in the third BUSY cycle.
        xfer("read_ack2", 32'h3000_0004, 32'h0, 1'b0, 4'hF, 1'b1, 1'b1, 2, 32'h1234_5678, -1);
        // No ack: timeout after exactly T strobe cycles.
        xfer("timeout", 32'h3000_0010, 32'h5555_AAAA, 1'b0, 4'hF, 1'b1, 1'b1, -1, 32'h0, -1);
        // Ack on the last allowed BUSY cycle wins over the timeout.
        xfer("ack_last", 32'h3000_0020, 32'h0, 1'b0, 4'h3, 1'b1, 1'b1, T - 1, 32'hCAFE_F00D, -1);
        // Fastest ack and a write ack (read data must be zero).
        xfer("ack_first", 32'h3000_0030, 32'h0, 1'b0, 4'h1, 1'b1, 1'b1, 0, 32'h0BAD_CAFE, -1);
        xfer("write_ack", 32'h3000_0040, 32'h7777_1111, 1'b1, 4'hC, 1'b1, 1'b1, 1, 32'hFFFF_FFFF, -1);
        // Return path disabled at request time: blocked, not a fault.
        xfer("blocked_wr", 32'h3000_0050, 32'h1111_2222, 1'b1, 4'hF, 1'b0, 1'b0, 0, 32'h0, -1);
        // Return path disabled during BUSY: the ack is ignored and it times out.
        xfer("iena_off", 32'h3000_0060, 32'h0, 1'b0, 4'hF, 1'b1, 1'b0, 3, 32'h1234_0000, -1);

        // Master abort three cycles into BUSY.
        @(negedge core_clk);
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_we_i  = 1'b0;
        m_adr_i = 32'h3000_0070;
        for (int i = 0; i < 3; i++) begin
            @(negedge core_clk);
            check("abort.busy_stb", {31'h0, mprj_stb_o}, 32'h1);
        end
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        @(negedge core_clk);
        check("abort.stb_low", {31'h0, mprj_stb_o}, 32'h0);
        check("abort.cyc_low", {31'h0, mprj_cyc_o}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("abort.no_ack", {31'h0, m_ack_o}, 32'h0);
            @(negedge core_clk);
        end
        check_faults("abort");

        // Randomized transfers against the model.
        for (int k = 0; k < 24; k++) begin
            xfer("rand", $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) != 0),
                 $urandom_range(0, 10), $urandom,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1);
        end

        // Make sure fault registers are non-zero, then reset mid-BUSY.
        xfer("pre_rst", 32'h3000_0080, 32'h0, 1'b0, 4'hF, 1'b1, 1'b1, -1, 32'h0, -1);
        @(negedge core_clk);
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_we_i  = 1'b1;
        m_sel_i = 4'hA;
        m_adr_i = 32'h3000_0090;
        m_dat_i = 32'h9999_8888;
        repeat (2) @(negedge core_clk);
        #2 core_rstn = 1'b0;
        #1;
        exp_cnt = 0;
        exp_irq = 1'b0;
        exp_adr = 32'h0;
        check("rst_mid.m_ack", {31'h0, m_ack_o}, 32'h0);
        check("rst_mid.cyc", {31'h0, mprj_cyc_o}, 32'h0);
        check("rst_mid.stb", {31'h0, mprj_stb_o}, 32'h0);
        check("rst_mid.we", {31'h0, mprj_we_o}, 32'h0);
        check("rst_mid.sel", {28'h0, mprj_sel_o}, 32'h0);
        check("rst_mid.adr", mprj_adr_o, 32'h0);
        check("rst_mid.wdat", mprj_dat_o, 32'h0);
        check("rst_mid.m_dat", m_dat_o, 32'h0);
        check_faults("rst_mid");
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        @(negedge core_clk);
        core_rstn = 1'b1;
        @(negedge core_clk);
        check("rst_rel.m_ack", {31'h0, m_ack_o}, 32'h0);
        check("rst_rel.stb", {31'h0, mprj_stb_o}, 32'h0);
        xfer("post_rst", 32'h3000_00A0, 32'h0, 1'b0, 4'hF, 1'b1, 1'b1, 1, 32'h4242_4242, -1);

        // Fault clear while idle leaves fault_adr alone.
        xfer("pre_clr", 32'h3000_00B0, 32'h0, 1'b0, 4'hF, 1'b1, 1'b1, -1, 32'h0, -1);
        @(negedge core_clk);
        fault_clr = 1'b1;
        @(negedge core_clk);
        fault_clr = 1'b0;
        exp_cnt = 0;
        exp_irq = 1'b0;
        check_faults("idle_clr");

        // Saturation after 256 consecutive timeouts.
        for (int k = 0; k < 256; k++) begin
            xfer("sat", 32'h3000_1000 + 32'(k), 32'h0, 1'b0, 4'hF, 1'b1, 1'b1, -1, 32'h0, -1);
        end
        check("sat.cnt255", {24'h0, fault_cnt}, 32'd255);

        // Clear coinciding with a new timeout: the timeout wins.
        xfer("clr_vs_to", 32'h3000_2000, 32'h0, 1'b0, 4'hF, 1'b1, 1'b1, -1, 32'h0, T - 1);
        check("clr_vs_to.cnt1", {24'h0, fault_cnt}, 32'd1);
        check("clr_vs_to.irq1", {31'h0, timeout_irq}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
